// File: rtl/wb_reg_slave.sv
// wb_reg_slave: Wishbone classic-cycle register slave for the SPI master core.
// Holds NREG general words, a sticky IRQ status register (write-1-to-clear),
// an IRQ enable mask, programmable wait states and optional error termination.
// Optional feature macro: WB_REG_SLAVE_ERR_EN. When it is defined, an
// out-of-range index or an empty byte select ends the transfer with wb_err_o.
// When it is undefined, those transfers are acked, writes are dropped and
// reads return 0.
module wb_reg_slave #(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int NREG  = 6,
  parameter int WAIT  = 0,
  parameter int IRQ_W = 8
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic [AW-1:0]        wb_adr_i,
  input  logic [DW-1:0]        wb_dat_i,
  output logic [DW-1:0]        wb_dat_o,
  input  logic [DW/8-1:0]      wb_sel_i,
  input  logic                 wb_we_i,
  input  logic                 wb_stb_i,
  input  logic                 wb_cyc_i,
  output logic                 wb_ack_o,
  output logic                 wb_err_o,
  output logic                 wb_int_o,
  output logic [NREG*DW-1:0]   reg_q_o,
  output logic [NREG-1:0]      reg_wr_o,
  input  logic [IRQ_W-1:0]     irq_src_i
);
  localparam int SW = DW/8;
  localparam int IW = AW-2;
  localparam logic [IW-1:0] IDX_STAT  = IW'(NREG);
  localparam logic [IW-1:0] IDX_EN    = IW'(NREG+1);
  localparam logic [3:0]    WAIT_LAST = 4'(WAIT-1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t state_q, state_d;
  logic [3:0]    cnt_q;
  logic [IW-1:0] adr_q;
  logic [DW-1:0] dat_q;
  logic [SW-1:0] sel_q;
  logic          we_q;

  logic [NREG-1:0][DW-1:0] regs;
  logic [IRQ_W-1:0]        stat_q, en_q, clr;
  logic                    int_q;

  logic          req, commit, wr_go, cur_bad, bad_q, in_resp;
  logic [IW-1:0] cur_adr;
  logic [DW-1:0] cur_dat, wmask, rdata;
  logic [SW-1:0] cur_sel;
  logic          cur_we;

  // Byte-offset address bits carry no information for word registers.
  logic unused_adr;
  assign unused_adr = &{1'b0, wb_adr_i[1:0]};

  assign req     = wb_cyc_i & wb_stb_i;
  assign in_resp = (state_q == S_RESP);

  // Transaction fields: live bus in IDLE (zero-wait commit happens on the
  // request edge itself), captured copy once the request has been taken.
  always_comb begin
    cur_adr = adr_q;
    cur_dat = dat_q;
    cur_sel = sel_q;
    cur_we  = we_q;
    if (state_q == S_IDLE) begin
      cur_adr = wb_adr_i[AW-1:2];
      cur_dat = wb_dat_i;
      cur_sel = wb_sel_i;
      cur_we  = wb_we_i;
    end
  end

  assign cur_bad = (32'(cur_adr) > 32'(NREG+1)) || (cur_sel == '0);
  assign bad_q   = (32'(adr_q)   > 32'(NREG+1)) || (sel_q   == '0);

  // Expand byte selects into a bit mask for the merge.
  always_comb begin
    wmask = '0;
    for (int b = 0; b < SW; b++) wmask[b*8 +: 8] = {8{cur_sel[b]}};
  end

  // Next-state logic; commit marks the edge that enters RESP.
  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    unique case (state_q)
      S_IDLE: if (req) begin
        if (WAIT == 0) begin
          state_d = S_RESP;
          commit  = 1'b1;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!req) state_d = S_IDLE;
        else if (cnt_q == WAIT_LAST) begin
          state_d = S_RESP;
          commit  = 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign wr_go = commit & cur_we & ~cur_bad;

  // State register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Capture the request and count wait cycles.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      adr_q <= '0;
      dat_q <= '0;
      sel_q <= '0;
      we_q  <= 1'b0;
      cnt_q <= '0;
    end else if (state_q == S_IDLE && req) begin
      adr_q <= wb_adr_i[AW-1:2];
      dat_q <= wb_dat_i;
      sel_q <= wb_sel_i;
      we_q  <= wb_we_i;
      cnt_q <= '0;
    end else if (state_q == S_WAIT) begin
      cnt_q <= cnt_q + 4'd1;
    end
  end

  // General registers: byte-lane merge on commit.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) regs <= '0;
    else if (wr_go) begin
      for (int i = 0; i < NREG; i++)
        if (cur_adr == IW'(i)) regs[i] <= (regs[i] & ~wmask) | (cur_dat & wmask);
    end
  end

  assign clr = (wr_go && cur_adr == IDX_STAT) ? (cur_dat[IRQ_W-1:0] & wmask[IRQ_W-1:0]) : '0;

  // Sticky IRQ status (set beats clear), enable mask, registered interrupt.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      stat_q <= '0;
      en_q   <= '0;
      int_q  <= 1'b0;
    end else begin
      stat_q <= (stat_q & ~clr) | irq_src_i;
      if (wr_go && cur_adr == IDX_EN)
        en_q <= (en_q & ~wmask[IRQ_W-1:0]) | (cur_dat[IRQ_W-1:0] & wmask[IRQ_W-1:0]);
      int_q  <= |(stat_q & en_q);
    end
  end

  // Read mux over the captured index.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NREG; i++)
      if (adr_q == IW'(i)) rdata = regs[i];
    if (adr_q == IDX_STAT) rdata = DW'(stat_q);
    if (adr_q == IDX_EN)   rdata = DW'(en_q);
  end

  assign wb_dat_o = (in_resp && !we_q && !bad_q) ? rdata : '0;
`ifdef WB_REG_SLAVE_ERR_EN
  assign wb_ack_o = in_resp & ~bad_q;
  assign wb_err_o = in_resp &  bad_q;
`else
  assign wb_ack_o = in_resp;
  assign wb_err_o = 1'b0;
`endif
  assign wb_int_o = int_q;
  assign reg_q_o  = regs;

  // Write strobes line up with the termination cycle.
  always_comb begin
    reg_wr_o = '0;
    for (int i = 0; i < NREG; i++)
      reg_wr_o[i] = in_resp & we_q & ~bad_q & (adr_q == IW'(i));
  end
endmodule
